cpu_controller: RTL and testbench

Eight-phase control sequencer for the 8-bit RISC CPU. It sits directly downstream of the instruction register and consumes its 3-bit opcode, plus the accumulator zero flag. Each phase it drives the memory, program-counter, IR-load, accumulator and bus-enable strobes for the fetch/execute cycle. A HLT instruction freezes the machine until reset.

---
 rtl/cpu_controller_pkg.sv | 41 ++++
 rtl/cpu_controller_ctrl_decode.sv | 31 +++
 rtl/cpu_controller.sv | 70 +++++++
 tb/tb_cpu_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: opcode/phase encodings and strobe bundle shared by the controller
package cpu_controller_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } strobes_t;

    localparam strobes_t STROBES_RESET = strobes_t'(9'b1_0000_0000);
    localparam strobes_t STROBES_HALT  = strobes_t'(9'b0_0000_0001);

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_ctrl_decode.sv
// ctrl_decode: combinational strobe decode for the phase about to be entered
module ctrl_decode
    import cpu_controller_pkg::*;
(
    input  logic [2:0] next_phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    output strobes_t   strobes
);

    logic alu;
    logic exe_late;

    // strobe pattern of each phase, qualified by the instruction class
    always_comb begin
        alu            = is_aluop(opcode);
        exe_late       = (next_phase == PH_ALU_OP) || (next_phase == PH_STORE);
        strobes        = '0;
        strobes.sel    = next_phase < PH_OP_ADDR;
        strobes.rd     = ((next_phase != PH_INST_ADDR) && (next_phase < PH_OP_ADDR)) ||
                         ((next_phase >= PH_OP_FETCH) && alu);
        strobes.ld_ir  = (next_phase == PH_INST_LOAD) || (next_phase == PH_IDLE);
        strobes.inc_pc = (next_phase == PH_OP_ADDR) ||
                         ((next_phase == PH_ALU_OP) && (opcode == OP_SKZ) && zero);
        strobes.ld_pc  = exe_late && (opcode == OP_JMP);
        strobes.ld_ac  = (next_phase == PH_STORE) && alu;
        strobes.wr     = (next_phase == PH_STORE) && (opcode == OP_STO);
        strobes.data_e = exe_late && (opcode == OP_STO);
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase fetch/execute sequencer with registered strobes and halt
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);

    logic [2:0] phase_q, phase_d;
    logic [2:0] op_q, op_d;
    logic       halted_q, halted_d;
    logic       enter_halt;
    strobes_t   out_q, out_d, dec;

    // decode against the next phase so registered strobes line up with phase
    ctrl_decode u_decode (
        .next_phase (phase_d),
        .opcode     (op_d),
        .zero       (zero),
        .strobes    (dec)
    );

    // next phase, opcode latch, halt entry and next strobe set
    always_comb begin
        enter_halt = !halted_q && (phase_q == PH_IDLE) && (opcode == OP_HLT);
        op_d       = (!halted_q && (phase_q == PH_IDLE)) ? opcode : op_q;
        phase_d    = halted_q ? phase_q : phase_q + 3'd1;
        halted_d   = halted_q || enter_halt;
        out_d      = halted_q ? out_q : enter_halt ? STROBES_HALT : dec;
    end

    // state and output registers, reset overriding everything including halt
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            op_q     <= OP_HLT;
            halted_q <= 1'b0;
            out_q    <= STROBES_RESET;
        end else begin
            phase_q  <= phase_d;
            op_q     <= op_d;
            halted_q <= halted_d;
            out_q    <= out_d;
        end
    end

    assign phase  = phase_q;
    assign sel    = out_q.sel;
    assign rd     = out_q.rd;
    assign ld_ir  = out_q.ld_ir;
    assign inc_pc = out_q.inc_pc;
    assign ld_pc  = out_q.ld_pc;
    assign ld_ac  = out_q.ld_ac;
    assign wr     = out_q.wr;
    assign data_e = out_q.data_e;
    assign halt   = out_q.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: scoreboard bench with directed per-phase expectations
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb_q[$];
    logic [11:0] mon_exp, mon_act;

    // strobe order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
    localparam logic [8:0] S0  = 9'b100000000;
    localparam logic [8:0] S1  = 9'b110000000;
    localparam logic [8:0] S2  = 9'b111000000;
    localparam logic [8:0] S4  = 9'b000100000;
    localparam logic [8:0] SN  = 9'b000000000;
    localparam logic [8:0] SH  = 9'b000000001;
    localparam logic [8:0] SA  = 9'b010000000;
    localparam logic [8:0] SA7 = 9'b010001000;
    localparam logic [8:0] SS6 = 9'b000000010;
    localparam logic [8:0] SS7 = 9'b000000110;
    localparam logic [8:0] SJ  = 9'b000010000;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            mon_act = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL check%0d phase+strobes got=%b_%b want=%b_%b",
                         total, mon_act[11:9], mon_act[8:0], mon_exp[11:9], mon_exp[8:0]);
            end
        end
    end

    task automatic cyc(input logic [2:0] ph, input logic [8:0] s);
        @(posedge clk);
        #1;
        sb_q.push_back({ph, s});
    endtask

    task automatic run(input logic [2:0] op, input logic z, input logic [2:0] op5,
                       input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
        opcode = op;
        zero   = z;
        cyc(3'd1, S1);
        cyc(3'd2, S2);
        cyc(3'd3, S2);
        cyc(3'd4, S4);
        cyc(3'd5, e5);
        opcode = op5;
        cyc(3'd6, e6);
        cyc(3'd7, e7);
        cyc(3'd0, S0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        opcode = 3'd2;
        zero   = 1'b0;
        cyc(3'd0, S0);
        cyc(3'd0, S0);
        rst = 1'b0;
        run(3'd2, 1'b0, 3'd2, SA, SA, SA7);
        run(3'd1, 1'b1, 3'd1, SN, S4, SN);
        run(3'd1, 1'b0, 3'd1, SN, SN, SN);
        run(3'd6, 1'b0, 3'd6, SN, SS6, SS7);
        run(3'd7, 1'b0, 3'd7, SN, SJ, SJ);
        run(3'd2, 1'b0, 3'd6, SA, SA, SA7);
        run(3'd5, 1'b1, 3'd5, SA, SA, SA7);
        opcode = 3'd0;
        cyc(3'd1, S1);
        cyc(3'd2, S2);
        cyc(3'd3, S2);
        cyc(3'd4, SH);
        for (int i = 0; i < 22; i++) begin
            opcode = 3'($urandom_range(7));
            zero   = 1'($urandom_range(1));
            cyc(3'd4, SH);
        end
        rst = 1'b1;
        cyc(3'd0, S0);
        rst    = 1'b0;
        opcode = 3'd7;
        zero   = 1'b0;
        cyc(3'd1, S1);
        cyc(3'd2, S2);
        cyc(3'd3, S2);
        cyc(3'd4, S4);
        cyc(3'd5, SN);
        cyc(3'd6, SJ);
        rst = 1'b1;
        cyc(3'd0, S0);
        rst = 1'b0;
        cyc(3'd1, S1);
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
